burst_sequencer: RTL

BURST_SEQUENCER -- requirements
Module: burst_sequencer

---
 rtl/burst_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/burst_sequencer.sv
// burst_sequencer
//   Burst strobe generator. An accepted request produces one START cycle,
//   GAP_CYCLES idle cycles, BURST_LEN cycles of `a`, and one STOP cycle,
//   then returns to IDLE.
//
//   Parameters
//     BURST_LEN  (1..255) cycles `a` is held high per burst
//     GAP_CYCLES (0..15)  idle cycles between START and the first `a` cycle
//
//   Ports
//     clk     in   clock, rising edge
//     rst     in   synchronous active-high reset
//     req     in   burst request, level-sampled, accepted only in IDLE
//     ack     out  one-cycle request-acceptance pulse (coincides with start)
//     start   out  one-cycle burst-open pulse
//     a       out  burst-active strobe
//     stop    out  one-cycle burst-close pulse
//     busy    out  high in every state except IDLE
//     abort   in   burst cancel            (only with SEQ_ABORT_EN)
//     aborted out  one-cycle cancel pulse  (only with SEQ_ABORT_EN)
//
//   Build option
//     SEQ_ABORT_EN  define to add abort/aborted; when undefined every burst
//                   runs to completion.
module burst_sequencer #(
  parameter int unsigned BURST_LEN  = 3,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic ack,
  output logic start,
  output logic a,
  output logic stop,
  output logic busy
`ifdef SEQ_ABORT_EN
  ,
  input  logic abort,
  output logic aborted
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    GAP,
    ACTIVE,
    STOP
  } state_t;

  // Down-counters hold (remaining cycles - 1); zero marks the final cycle.
  localparam logic [7:0] ACTIVE_LOAD = 8'(BURST_LEN - 1);
  localparam logic [7:0] GAP_LOAD    = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
`ifdef SEQ_ABORT_EN
  logic       cancel;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef SEQ_ABORT_EN
    cancel    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (GAP_CYCLES > 0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          state_nxt = ACTIVE;
          cnt_nxt   = ACTIVE_LOAD;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = ACTIVE;
          cnt_nxt   = ACTIVE_LOAD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      ACTIVE: begin
        if (cnt == '0) begin
          state_nxt = STOP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      STOP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
`ifdef SEQ_ABORT_EN
    if (abort && (state == START || state == GAP || state == ACTIVE)) begin
      cancel    = 1'b1;
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
`endif
  end

  // Outputs are registered from the next state so that during any cycle
  // they reflect exactly the state being occupied, with no comb decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ack     <= 1'b0;
      start   <= 1'b0;
      a       <= 1'b0;
      stop    <= 1'b0;
      busy    <= 1'b0;
`ifdef SEQ_ABORT_EN
      aborted <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ack     <= (state_nxt == START);
      start   <= (state_nxt == START);
      a       <= (state_nxt == ACTIVE);
      stop    <= (state_nxt == STOP);
      busy    <= (state_nxt != IDLE);
`ifdef SEQ_ABORT_EN
      aborted <= cancel;
`endif
    end
  end

endmodule
